// File: rtl/conv_engine.sv
// Streaming 5x5 valid convolution over a MAPSIZE x MAPSIZE signed 8-bit map.
// Four line buffers feed a 5x5 window; products and their sum are pipelined to a 3-cycle latency.
module conv_engine #(
  parameter int MAPSIZE = 32,
  localparam int OUTPUT_COUNT = (MAPSIZE - 4) * (MAPSIZE - 4),
  localparam int AW = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          data_valid_in,
  input  logic signed [7:0]             pixel_in,
  input  logic signed [4:0][4:0][7:0]   weights,
  output logic [AW-1:0]                 mem_wr_addr,
  output logic signed [31:0]            mem_wr_data,
  output logic                          mem_wr_en,
  output logic                          all_done
);

  localparam int CW = (MAPSIZE > 1) ? $clog2(MAPSIZE) : 1;
  localparam logic [CW-1:0] LAST_POS   = CW'(MAPSIZE - 1);
  localparam logic [CW-1:0] FIRST_FULL = CW'(4);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(OUTPUT_COUNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      row;
  logic [CW-1:0]      col;
  logic [AW-1:0]      wr_count;
  logic               win_valid;
  logic               prod_valid;
  logic signed [7:0]  line_buf [4][MAPSIZE];
  logic signed [7:0]  win [5][5];
  logic signed [15:0] prod [5][5];
  logic signed [31:0] sum;
  logic               accept;
  logic               complete;
  logic               last_pixel;

  assign accept     = !rst && !start && (state == S_RUN) && data_valid_in;
  assign complete   = (row >= FIRST_FULL) && (col >= FIRST_FULL);
  assign last_pixel = (row == LAST_POS) && (col == LAST_POS);
  assign all_done   = (state == S_DONE);

  // line_buf[0] holds the previous row, line_buf[3] the row four above; win[0] is the top row
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= pixel_in;
      for (int i = 1; i < 4; i++) begin
        line_buf[i][col] <= line_buf[i-1][col];
      end
      for (int a = 0; a < 5; a++) begin
        for (int b = 0; b < 4; b++) begin
          win[a][b] <= win[a][b+1];
        end
      end
      win[0][4] <= line_buf[3][col];
      win[1][4] <= line_buf[2][col];
      win[2][4] <= line_buf[1][col];
      win[3][4] <= line_buf[0][col];
      win[4][4] <= pixel_in;
    end
    for (int a = 0; a < 5; a++) begin
      for (int b = 0; b < 5; b++) begin
        prod[a][b] <= 16'(win[a][b]) * 16'($signed(weights[4-a][4-b]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int a = 0; a < 5; a++) begin
      for (int b = 0; b < 5; b++) begin
        sum = sum + 32'(prod[a][b]);
      end
    end
  end

  // start restarts the frame from any state; in-flight results of an aborted frame are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      wr_count    <= '0;
      win_valid   <= 1'b0;
      prod_valid  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (start) begin
      state      <= S_RUN;
      row        <= '0;
      col        <= '0;
      wr_count   <= '0;
      win_valid  <= 1'b0;
      prod_valid <= 1'b0;
      mem_wr_en  <= 1'b0;
    end else begin
      win_valid  <= accept && complete;
      prod_valid <= win_valid;
      mem_wr_en  <= prod_valid;
      if (prod_valid) begin
        mem_wr_data <= sum;
        mem_wr_addr <= wr_count;
        wr_count    <= wr_count + AW'(1);
      end
      if (accept) begin
        if (col == LAST_POS) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (last_pixel) begin
          state <= S_DRAIN;
        end
      end
      if ((state == S_DRAIN) && mem_wr_en && (mem_wr_addr == LAST_ADDR)) begin
        state <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: table of frame cases checked against a scoreboard
// built from a direct convolution model, plus restart, reset-in-drain and idle/done sequences.
module tb_conv_engine;

  localparam int MAPSIZE = 32;
  localparam int OW = MAPSIZE - 4;
  localparam int OUTPUT_COUNT = OW * OW;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic                        data_valid_in;
  logic signed [7:0]           pixel_in;
  logic signed [4:0][4:0][7:0] weights;
  logic [9:0]                  mem_wr_addr;
  logic signed [31:0]          mem_wr_data;
  logic                        mem_wr_en;
  logic                        all_done;

  conv_engine #(.MAPSIZE(MAPSIZE)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_valid_in(data_valid_in),
    .pixel_in(pixel_in),
    .weights(weights),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en),
    .all_done(all_done)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    int          ksel;
    int          psel;
    int          gap_pct;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[6];
  int          img[MAPSIZE][MAPSIZE];
  int          kern[5][5];
  int          lap[5][5] = '{'{0, 0, -1, 0, 0}, '{0, -1, -2, -1, 0}, '{-1, -2, 16, -2, -1},
                             '{0, -1, -2, -1, 0}, '{0, 0, -1, 0, 0}};
  logic [31:0] cap[OUTPUT_COUNT];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wr_seen = 0;
  bit          done_pending = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               name, $signed(actual), actual, $signed(expected), expected);
    end
  endtask

  function automatic logic [31:0] model_out(int r, int c);
    int acc = 0;
    for (int a = 0; a < 5; a++) begin
      for (int b = 0; b < 5; b++) begin
        acc += kern[4-a][4-b] * img[r+a][c+b];
      end
    end
    return 32'(acc);
  endfunction

  // Every write is matched in order against the scoreboard, including its cycle of arrival
  initial begin
    forever begin
      @(negedge clk);
      if (done_pending) begin
        checkOutput("all_done_rise", 32'(all_done), 32'd1);
        done_pending = 0;
      end
      if (mem_wr_en === 1'b1) begin
        wr_seen++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_write_en", 32'(mem_wr_en), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("wr_addr", 32'(mem_wr_addr), 32'(mon_e.addr));
          checkOutput("wr_data", mem_wr_data, mon_e.data);
          checkOutput("wr_latency", 32'(cyc), 32'(mon_e.cyc));
          if (int'(mem_wr_addr) < OUTPUT_COUNT) cap[int'(mem_wr_addr)] = mem_wr_data;
          if (mon_e.addr == OUTPUT_COUNT - 1) begin
            checkOutput("all_done_before_last", 32'(all_done), 32'd0);
            done_pending = 1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic load_case(int ksel, int psel);
    int v;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        case (ksel)
          0:       kern[i][j] = lap[i][j];
          1:       kern[i][j] = (i == 4 && j == 4) ? 1 : 0;
          default: kern[i][j] = -128;
        endcase
        weights[i][j] = 8'(kern[i][j]);
      end
    end
    for (int r = 0; r < MAPSIZE; r++) begin
      for (int c = 0; c < MAPSIZE; c++) begin
        case (psel)
          0: img[r][c] = 7;
          1: img[r][c] = (r == 2 && c == 2) ? 1 : 0;
          2: begin
            v = (r * MAPSIZE + c) % 256;
            img[r][c] = (v > 127) ? v - 256 : v;
          end
          3: img[r][c] = -128;
          default: img[r][c] = 127;
        endcase
      end
    end
  endtask

  // Drops expected writes that an abort on the edge after cycle s will cancel
  task automatic prune(int s);
    while (sb.size() > 0 && sb[sb.size()-1].cyc > s) void'(sb.pop_back());
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    data_valid_in = 1'b0;
    prune(cyc);
    @(negedge clk);
    start = 1'b0;
    wr_seen = 0;
    checkOutput("all_done_after_start", 32'(all_done), 32'd0);
  endtask

  task automatic drive_pixels(int first, int last, int gap_pct);
    int r;
    int c;
    for (int idx = first; idx <= last; idx++) begin
      r = idx / MAPSIZE;
      c = idx % MAPSIZE;
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        data_valid_in = 1'b0;
        pixel_in = 8'($urandom);
      end
      @(negedge clk);
      data_valid_in = 1'b1;
      pixel_in = 8'(img[r][c]);
      if (r >= 4 && c >= 4) sb.push_back('{(r - 4) * OW + (c - 4), model_out(r - 4, c - 4), cyc + 3});
    end
  endtask

  // Keeps presenting junk pixels while draining; they must be ignored
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk);
      data_valid_in = 1'b1;
      pixel_in = 8'($urandom);
      n++;
    end
    checkOutput("drain_complete", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    data_valid_in = 1'b0;
  endtask

  task automatic idle_pixels(int n);
    repeat (n) begin
      @(negedge clk);
      data_valid_in = 1'b1;
      pixel_in = 8'($urandom);
    end
    @(negedge clk);
    data_valid_in = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    checkOutput({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(mem_wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, mem_wr_data, 32'd0);
    checkOutput({tag, "_all_done"}, 32'(all_done), 32'd0);
  endtask

  task automatic applyStimulus(vec_t v);
    load_case(v.ksel, v.psel);
    start_pulse();
    drive_pixels(0, MAPSIZE * MAPSIZE - 1, v.gap_pct);
    wait_drain();
  endtask

  task automatic check_frame(vec_t v);
    checkOutput({v.name, "_write_count"}, 32'(wr_seen), 32'(OUTPUT_COUNT));
    checkOutput({v.name, "_all_done"}, 32'(all_done), 32'd1);
    checkOutput({v.name, "_addr0"}, cap[0], v.exp0);
    checkOutput({v.name, "_addr1"}, cap[1], v.exp1);
    checkOutput({v.name, "_addr2"}, cap[2], v.exp2);
  endtask

  initial begin
    int w;
    vecs[0] = '{"zero_sum_const", 0, 0, 0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{"impulse",        0, 1, 0,  32'h0000_0010, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    vecs[2] = '{"identity_gaps",  1, 2, 30, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002};
    vecs[3] = '{"identity_nogap", 1, 2, 0,  32'h0000_0000, 32'h0000_0001, 32'h0000_0002};
    vecs[4] = '{"neg_extreme",    2, 3, 0,  32'h0006_4000, 32'h0006_4000, 32'h0006_4000};
    vecs[5] = '{"pos_extreme",    2, 4, 0,  32'hFFF9_CC80, 32'hFFF9_CC80, 32'hFFF9_CC80};

    rst = 1'b1;
    start = 1'b0;
    data_valid_in = 1'b0;
    pixel_in = '0;
    weights = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    $display("[TB] pixels before any start");
    idle_pixels(40);
    checkOutput("idle_no_writes", 32'(wr_seen), 32'd0);
    checkOutput("idle_all_done", 32'(all_done), 32'd0);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] frame case %s", vecs[i].name);
      applyStimulus(vecs[i]);
      check_frame(vecs[i]);
      w = wr_seen;
      idle_pixels(40);
      checkOutput({vecs[i].name, "_done_no_writes"}, 32'(wr_seen), 32'(w));
      checkOutput({vecs[i].name, "_all_done_sticky"}, 32'(all_done), 32'd1);
    end

    $display("[TB] restart mid-run");
    load_case(0, 2);
    start_pulse();
    drive_pixels(0, 299, 0);
    start_pulse();
    drive_pixels(0, MAPSIZE * MAPSIZE - 1, 10);
    wait_drain();
    checkOutput("restart_write_count", 32'(wr_seen), 32'(OUTPUT_COUNT));
    checkOutput("restart_all_done", 32'(all_done), 32'd1);

    $display("[TB] reset during drain");
    load_case(1, 2);
    start_pulse();
    drive_pixels(0, MAPSIZE * MAPSIZE - 1, 0);
    @(negedge clk);
    rst = 1'b1;
    data_valid_in = 1'b0;
    prune(cyc);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("drain_reset");
    w = wr_seen;
    idle_pixels(20);
    checkOutput("drain_reset_no_writes", 32'(wr_seen), 32'(w));
    checkOutput("drain_reset_all_done", 32'(all_done), 32'd0);
    sb.delete();

    $display("[TB] recovery frame");
    applyStimulus(vecs[1]);
    check_frame(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
# conv_engine

Streaming 5x5 "valid" convolution engine for one square feature map of signed 8-bit pixels in raster order. Uses four line buffers and a 5x5 window register, multiplies by a static 5x5 signed 8-bit kernel and accumulates in full precision. Each result is written to an output memory as (address, 32-bit data, write enable), in raster order of output positions. Sits between the input pixel stream and the output feature-map RAM in the CNN accelerator datapath.

## Interface
- MAPSIZE, 32, input map width = height (>= 5).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- start  in  1  single-cycle pulse that arms the engine for a new frame.
- data_valid_in  in  1  pixel_in is valid this cycle.
- pixel_in  in  8 signed  input pixel, raster order (row 0 col 0 first).
- weights  in  [4:0][4:0] x 8 signed  kernel; static while RUN/DRAIN.
- mem_wr_addr  out  $clog2((MAPSIZE-4)^2)  output index.
- mem_wr_data  out  32 signed  convolution result.
- mem_wr_en  out  1  write strobe, one cycle per result.
- all_done  out  1  frame complete; sticky.

## Operation
- Output count is OUTPUT_COUNT = (MAPSIZE-4)^2 (784 for MAPSIZE=32).
- Result at output row R, column C, for R,C in 0..MAPSIZE-5: out(R,C) = sum over a,b in 0..4 of weights[4-a][4-b] * pixel(R+a, C+b).
  - weights[4][4] is the top-left tap; weights[0][0] is the bottom-right tap.
- Address is R*(MAPSIZE-4)+C. Results are written in strictly increasing address order, each exactly once.
- Arithmetic:
  - Products are signed 8x8 -> 16-bit.
  - Products are summed sign-extended, with no saturation or rounding.
  - The result is sign-extended to 32 bits.
- States:
  - IDLE (after reset): data_valid_in is ignored. start -> RUN.
  - RUN: a pixel is accepted on each cycle with data_valid_in=1; row/col counters advance only on accepted pixels. After MAPSIZE^2 pixels are accepted -> DRAIN.
  - DRAIN: further data_valid_in is ignored. When the last result (address OUTPUT_COUNT-1) is written -> DONE.
  - DONE: all_done=1. data_valid_in is ignored. start -> RUN.
- start in RUN or DRAIN:
  - Aborts the frame: clears pixel counters, address counter and in-flight pipeline valids, then re-enters RUN.
  - Line buffer contents need not be cleared.
- A window is "complete" when the accepted pixel is at row >= 4 and col >= 4. Only complete windows produce results; columns 0..3 never produce output, so there is no row wrap contamination.

## Timing
- Reset values: mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, all_done=0, state IDLE, all counters 0.
- Latency is fixed at 3 cycles. If the pixel completing a window is accepted at clock edge k:
  - edge k: window register updated;
  - edge k+1: 25 products registered;
  - edge k+2: sum registered to mem_wr_data/mem_wr_addr with mem_wr_en=1.
  - mem_wr_en is therefore high in the cycle after edge k+2.
- mem_wr_en is high for exactly one cycle per result. mem_wr_data and mem_wr_addr hold their last values while mem_wr_en=0.
- Back-to-back valid pixels give back-to-back writes within a row. Gaps in data_valid_in delay results but never change values or order.
- The output pipeline drains independently of data_valid_in.
- all_done rises on the edge after the final write's mem_wr_en cycle. It stays high until start or rst.
- rst at any point overrides everything, including start, and restores the reset values on that edge.
- start and rst are both sampled only on clock edges.

## Test plan
- **Zero-sum kernel, constant image.** MAPSIZE=32, kernel rows {0,0,-1,0,0},{0,-1,-2,-1,0},{-1,-2,16,-2,-1},{0,-1,-2,-1,0},{0,0,-1,0,0}, all pixels 7 -> 784 writes, every mem_wr_data=0, addresses 0..783 in order, all_done rises after write 783.
- **Impulse.** Same kernel, pixel(2,2)=1, others 0 -> addr 0 = 0x00000010, addr 1 = 0xFFFFFFFE (tap -2), addr 2 = 0xFFFFFFFF, all windows not covering (2,2) = 0.
- **Identity tap and gaps.** weights[4][4]=1, others 0, pixel(i) = i mod 256 as signed, data_valid_in randomly low ~30% -> out(R,C) = pixel(R,C) sign-extended, identical to the gap-free run, with 3-cycle latency from the completing pixel.
- **Extreme values.** All pixels -128, all weights -128 -> every output 409600 = 0x00064000. All pixels 127, all weights -128 -> -406400 = 0xFFF9CC80.
- **Restart and reset.**
  - start pulsed mid-RUN -> counters restart and the second full frame yields a correct 784-result sequence from addr 0.
  - rst mid-DRAIN -> outputs at reset values the next cycle, no further writes, all_done=0 until a new start and full frame.
- **Post-done behaviour.** Pixels presented in DONE or before start -> no writes. A second start plus frame -> all_done falls on start and rises again after 784 new writes.
